// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Address map, flag bit positions and decoded-op enum shared by
//            the wishbone ALU slave and its multiplier.
// Revision : 1.0
// ============================================================================
package alu_pkg;

   localparam logic [7:0] ADDR_A    = 8'h00;
   localparam logic [7:0] ADDR_B    = 8'h01;
   localparam logic [7:0] ADDR_F    = 8'h02;
   localparam logic [7:0] ADDR_ADD  = 8'h80;
   localparam logic [7:0] ADDR_ADC  = 8'h81;
   localparam logic [7:0] ADDR_SUB  = 8'h82;
   localparam logic [7:0] ADDR_SBC  = 8'h83;
   localparam logic [7:0] ADDR_AND  = 8'h84;
   localparam logic [7:0] ADDR_OR   = 8'h85;
   localparam logic [7:0] ADDR_XOR  = 8'h86;
   localparam logic [7:0] ADDR_ASL  = 8'h87;
   localparam logic [7:0] ADDR_LSR  = 8'h88;
   localparam logic [7:0] ADDR_ROL  = 8'h89;
   localparam logic [7:0] ADDR_ROR  = 8'h8A;
   localparam logic [7:0] ADDR_MUL  = 8'h8B;
   localparam logic [7:0] ADDR_MULH = 8'h8C;

   localparam int FLAG_N = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_Z = 1;
   localparam int FLAG_C = 0;

   typedef enum logic [4:0] {
      OP_RD_A, OP_RD_B, OP_RD_F,
      OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_AND, OP_OR, OP_XOR,
      OP_ASL, OP_LSR, OP_ROL, OP_ROR,
      OP_MUL, OP_MULH, OP_NONE
   } op_e;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : WIDTH-cycle shift-add unsigned multiplier, one bit per clock.
// Revision : 1.0
// ============================================================================
module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 reset_n,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_product
);

   localparam int                c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]         r_state;
   logic [0:0]         w_state_next;
   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH:0]     w_sum;

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_next = S_RUN;
         S_RUN:   if (r_cnt == c_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (r_state == S_RUN);
      o_done = (r_state == S_RUN) && (r_cnt == c_last);
   end

   // {r_hi, r_lo} is the running product; multiplier bits shift out of r_lo
   assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
   assign o_product = {w_sum, r_lo[WIDTH-1:1]};

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else if (r_state == S_IDLE) begin
         if (i_start) begin
            r_cnt   <= '0;
            r_mcand <= i_a;
            r_hi    <= '0;
            r_lo    <= i_b;
         end
      end else begin
         r_hi  <= w_sum[WIDTH:1];
         r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
         r_cnt <= r_cnt + c_cnt_w'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_wb_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_wb_seq
// Purpose  : Pipelined-wishbone arithmetic slave with 6502-style flags and a
//            stalling multi-cycle multiply.
// Revision : 1.0
// ============================================================================
module alu_wb_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 8,
   parameter int MUL_EN = 1
) (
   input  logic              i_clk,
   input  logic              reset_n,
   input  logic              i_wb_stb,
   input  logic              i_wb_we,
   input  logic [ADDR_W-1:0] i_wb_addr,
   input  logic [WIDTH-1:0]  i_wb_data,
   output logic              o_wb_ack,
   output logic              o_wb_stall,
   output logic [WIDTH-1:0]  o_wb_data
);

   localparam int c_msb = WIDTH - 1;

   logic [WIDTH-1:0]   r_a, r_b, r_data, r_p_hi;
   logic [3:0]         r_f;
   logic               r_ack;
   logic               w_busy, w_done, w_accept, w_mul_start, w_upd_nz;
   logic [2*WIDTH-1:0] w_prod;
   op_e                w_op;
   logic [WIDTH-1:0]   w_res, w_op2;
   logic [WIDTH:0]     w_sum;
   logic               w_cin;
   logic [3:0]         w_f_next;

   always_comb begin
      w_op = OP_NONE;
      case (i_wb_addr)
         ADDR_W'(ADDR_A):    w_op = OP_RD_A;
         ADDR_W'(ADDR_B):    w_op = OP_RD_B;
         ADDR_W'(ADDR_F):    w_op = OP_RD_F;
         ADDR_W'(ADDR_ADD):  w_op = OP_ADD;
         ADDR_W'(ADDR_ADC):  w_op = OP_ADC;
         ADDR_W'(ADDR_SUB):  w_op = OP_SUB;
         ADDR_W'(ADDR_SBC):  w_op = OP_SBC;
         ADDR_W'(ADDR_AND):  w_op = OP_AND;
         ADDR_W'(ADDR_OR):   w_op = OP_OR;
         ADDR_W'(ADDR_XOR):  w_op = OP_XOR;
         ADDR_W'(ADDR_ASL):  w_op = OP_ASL;
         ADDR_W'(ADDR_LSR):  w_op = OP_LSR;
         ADDR_W'(ADDR_ROL):  w_op = OP_ROL;
         ADDR_W'(ADDR_ROR):  w_op = OP_ROR;
         ADDR_W'(ADDR_MUL):  w_op = (MUL_EN != 0) ? OP_MUL  : OP_NONE;
         ADDR_W'(ADDR_MULH): w_op = (MUL_EN != 0) ? OP_MULH : OP_NONE;
         default:            w_op = OP_NONE;
      endcase
   end

   // Subtraction is A + ~B + carry-in, so C=1 means no borrow
   always_comb begin
      w_op2 = (w_op == OP_SUB || w_op == OP_SBC) ? ~r_b : r_b;
      w_cin = 1'b0;
      if (w_op == OP_SUB)                        w_cin = 1'b1;
      else if (w_op == OP_ADC || w_op == OP_SBC) w_cin = r_f[FLAG_C];
   end

   assign w_sum = {1'b0, r_a} + {1'b0, w_op2} + {{WIDTH{1'b0}}, w_cin};

   always_comb begin
      w_res    = '0;
      w_f_next = r_f;
      w_upd_nz = 1'b1;
      case (w_op)
         OP_RD_A: begin w_res = r_a;           w_upd_nz = 1'b0; end
         OP_RD_B: begin w_res = r_b;           w_upd_nz = 1'b0; end
         OP_RD_F: begin w_res = WIDTH'(r_f);   w_upd_nz = 1'b0; end
         OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
            w_res            = w_sum[c_msb:0];
            w_f_next[FLAG_C] = w_sum[WIDTH];
            w_f_next[FLAG_V] = (r_a[c_msb] == w_op2[c_msb]) && (w_sum[c_msb] != r_a[c_msb]);
         end
         OP_AND:  w_res = r_a & r_b;
         OP_OR:   w_res = r_a | r_b;
         OP_XOR:  w_res = r_a ^ r_b;
         OP_ASL:  begin w_res = {r_a[c_msb-1:0], 1'b0};       w_f_next[FLAG_C] = r_a[c_msb]; end
         OP_LSR:  begin w_res = {1'b0, r_a[c_msb:1]};         w_f_next[FLAG_C] = r_a[0];     end
         OP_ROL:  begin w_res = {r_a[c_msb-1:0], r_f[FLAG_C]}; w_f_next[FLAG_C] = r_a[c_msb]; end
         OP_ROR:  begin w_res = {r_f[FLAG_C], r_a[c_msb:1]};   w_f_next[FLAG_C] = r_a[0];     end
         OP_MULH: begin w_res = r_p_hi;        w_upd_nz = 1'b0; end
         default: begin w_res = '0;            w_upd_nz = 1'b0; end
      endcase
      if (w_upd_nz) begin
         w_f_next[FLAG_N] = w_res[c_msb];
         w_f_next[FLAG_Z] = (w_res == '0);
      end
   end

   assign w_accept    = i_wb_stb && !w_busy;
   assign w_mul_start = w_accept && !i_wb_we && (w_op == OP_MUL);

   generate
      if (MUL_EN != 0) begin : g_mul
         alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
            .i_clk     (i_clk),
            .reset_n   (reset_n),
            .i_start   (w_mul_start),
            .i_a       (r_a),
            .i_b       (r_b),
            .o_busy    (w_busy),
            .o_done    (w_done),
            .o_product (w_prod)
         );
      end else begin : g_no_mul
         assign w_busy = 1'b0;
         assign w_done = 1'b0;
         assign w_prod = '0;
      end
   endgenerate

   // Stall masks acceptance, so a multiply completion never collides with a request
   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_f    <= '0;
         r_p_hi <= '0;
         r_data <= '0;
         r_ack  <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         if (w_done) begin
            r_ack         <= 1'b1;
            r_data        <= w_prod[c_msb:0];
            r_p_hi        <= w_prod[2*WIDTH-1:WIDTH];
            r_f[FLAG_Z]   <= (w_prod == '0);
            r_f[FLAG_N]   <= w_prod[2*WIDTH-1];
         end else if (w_accept) begin
            if (i_wb_we) begin
               r_ack <= 1'b1;
               case (i_wb_addr)
                  ADDR_W'(ADDR_A): r_a <= i_wb_data;
                  ADDR_W'(ADDR_B): r_b <= i_wb_data;
                  ADDR_W'(ADDR_F): r_f <= i_wb_data[3:0];
                  default: ;
               endcase
            end else if (w_op != OP_MUL) begin
               r_ack  <= 1'b1;
               r_data <= w_res;
               r_f    <= w_f_next;
            end
         end
      end
   end

   assign o_wb_ack   = r_ack;
   assign o_wb_stall = w_busy;
   assign o_wb_data  = r_data;

endmodule
`default_nettype wire
